pipe_hazard_ctrl: RTL

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 118 +++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard control for a 5-stage pipeline: load-use stall, branch/jump flush, EX operand forwarding.
// Latency: all enables, flushes and forwarding selects are combinational; state and counters update on the clock edge.
// Backpressure: a load-use hazard holds PC and IF/ID for two cycles; a taken branch overrides and cancels any stall.
module pipe_hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_use_rs,
    input  logic        id_use_rt,
    input  logic        id_jump,
    input  logic [4:0]  ex_rs,
    input  logic [4:0]  ex_rt,
    input  logic        ex_regWr,
    input  logic        ex_mem2reg,
    input  logic [4:0]  ex_dst,
    input  logic        me_regWr,
    input  logic        me_mem2reg,
    input  logic [4:0]  me_dst,
    input  logic        me_br_taken,
    input  logic        wb_regWr,
    input  logic [4:0]  wb_dst,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        ex_me_flush,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt,
    output logic        state
);

    typedef enum logic {
        RUN     = 1'b0,
        LU_WAIT = 1'b1
    } state_t;

    state_t cur_state;
    logic   lu_hit;
    logic   any_flush;

    // Forwarding select for one EX source operand; ME ALU result wins over WB, $0 never forwards.
    // Loads in ME are excluded because their data is not available until WB.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       me_wr,
        input logic       me_ld,
        input logic [4:0] me_d,
        input logic       wb_wr,
        input logic [4:0] wb_d
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (src != 5'd0) begin
            if (me_wr && !me_ld && (me_d == src))
                sel = 2'b01;
            else if (wb_wr && (wb_d == src))
                sel = 2'b10;
        end
        return sel;
    endfunction

    // Prioritised control decode: branch > load-use stall > jump > run; reset forces the idle pattern.
    always_comb begin
        lu_hit      = ex_regWr & ex_mem2reg & (ex_dst != 5'd0) &
                      ((id_use_rs & (id_rs == ex_dst)) | (id_use_rt & (id_rt == ex_dst)));
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        ex_me_flush = 1'b0;
        fwd_a       = 2'b00;
        fwd_b       = 2'b00;
        if (!rst) begin
            if (me_br_taken) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                ex_me_flush = 1'b1;
            end else if ((cur_state == LU_WAIT) || lu_hit) begin
                // Hold fetch/decode and push a bubble into EX; a jump in ID waits here too.
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
            end else if (id_jump) begin
                if_id_flush = 1'b1;
            end
            fwd_a = fwd_sel(ex_rs, me_regWr, me_mem2reg, me_dst, wb_regWr, wb_dst);
            fwd_b = fwd_sel(ex_rt, me_regWr, me_mem2reg, me_dst, wb_regWr, wb_dst);
        end
    end

    assign any_flush = if_id_flush | id_ex_flush | ex_me_flush;
    assign state     = cur_state;

    // Stall FSM and saturating performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state <= RUN;
            stall_cnt <= 16'd0;
            flush_cnt <= 16'd0;
        end else begin
            if (me_br_taken)
                cur_state <= RUN;
            else if (cur_state == LU_WAIT)
                cur_state <= RUN;
            else if (lu_hit)
                cur_state <= LU_WAIT;

            if (!pc_en && (stall_cnt != 16'hFFFF))
                stall_cnt <= stall_cnt + 16'd1;
            if (any_flush && (flush_cnt != 16'hFFFF))
                flush_cnt <= flush_cnt + 16'd1;
        end
    end

endmodule
